// File: rtl/rf_access_master_if.sv
// Command, register-file and response signal bundle for rf_access_master.
// The master modport is the block's own view; slave is the command source/responder side.
interface rf_access_master_if #(
  parameter int ADDR_HI = 5,
  parameter int ADDR_LO = 3,
  parameter int DATA_W  = 64
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [ADDR_HI-ADDR_LO:0]   cmd_address;
  logic [DATA_W-1:0]          cmd_wdata;
  logic [ADDR_HI:ADDR_LO]     address;
  logic                       read_en;
  logic                       write_en;
  logic [DATA_W-1:0]          write_data;
  logic [DATA_W-1:0]          read_data;
  logic                       access_complete;
  logic                       invalid_address;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_W-1:0]          rsp_data;
  logic [1:0]                 rsp_status;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_wdata,
    input  read_data, access_complete, invalid_address, rsp_ready,
    output cmd_ready, address, read_en, write_en, write_data,
    output rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_wdata,
    output read_data, access_complete, invalid_address, rsp_ready,
    input  cmd_ready, address, read_en, write_en, write_data,
    input  rsp_valid, rsp_data, rsp_status
  );
endinterface

// File: rtl/rf_access_master.sv
// Single-outstanding register-file access master: accepts a command, strobes the
// register file once, waits for completion/decode miss/timeout and returns a response.
module rf_access_master #(
  parameter int ADDR_HI = 5,
  parameter int ADDR_LO = 3,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               res,
  rf_access_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_INVALID = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;
  localparam logic [7:0] TIMEOUT_CNT    = 8'(TIMEOUT);

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   cmd_write_r;
  logic [ADDR_HI:ADDR_LO] address_r;
  logic [DATA_W-1:0]      write_data_r;
  logic                   read_en_r;
  logic                   write_en_r;
  logic [7:0]             wait_cnt_r;
  logic [7:0]             wait_cnt_inc_s;
  logic                   rsp_valid_r;
  logic [DATA_W-1:0]      rsp_data_r;
  logic [1:0]             rsp_status_r;
  logic                   accept_s;
  logic                   load_rsp_s;
  logic [DATA_W-1:0]      rsp_data_s;
  logic [1:0]             rsp_status_s;

  assign bus.cmd_ready  = (state_r == IDLE) && !res;
  assign bus.address    = address_r;
  assign bus.write_data = write_data_r;
  assign bus.read_en    = read_en_r;
  assign bus.write_en   = write_en_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_status = rsp_status_r;

  // Next-state and response selection; a decode miss outranks completion,
  // and completion outranks the timeout expiring in the same cycle.
  always_comb begin
    state_next_s   = state_r;
    accept_s       = 1'b0;
    load_rsp_s     = 1'b0;
    rsp_data_s     = '0;
    rsp_status_s   = STATUS_OK;
    wait_cnt_inc_s = wait_cnt_r + 8'd1;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept_s     = 1'b1;
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE, WAIT: begin
        if (bus.invalid_address) begin
          load_rsp_s   = 1'b1;
          rsp_status_s = STATUS_INVALID;
          state_next_s = RESP;
        end else if (bus.access_complete) begin
          load_rsp_s   = 1'b1;
          rsp_status_s = STATUS_OK;
          rsp_data_s   = cmd_write_r ? {DATA_W{1'b0}} : bus.read_data;
          state_next_s = RESP;
        end else if ((state_r == WAIT) && (wait_cnt_inc_s == TIMEOUT_CNT)) begin
          load_rsp_s   = 1'b1;
          rsp_status_s = STATUS_TIMEOUT;
          state_next_s = RESP;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, command capture, one-cycle strobes, wait counter and response registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r      <= IDLE;
      cmd_write_r  <= 1'b0;
      address_r    <= '0;
      write_data_r <= '0;
      read_en_r    <= 1'b0;
      write_en_r   <= 1'b0;
      wait_cnt_r   <= 8'd0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= '0;
      rsp_status_r <= 2'b00;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        cmd_write_r  <= bus.cmd_write;
        address_r    <= bus.cmd_address;
        write_data_r <= bus.cmd_wdata;
      end
      // Strobes are high exactly in the ISSUE cycle that follows acceptance.
      read_en_r  <= accept_s && !bus.cmd_write;
      write_en_r <= accept_s && bus.cmd_write;
      if ((state_r == WAIT) && (state_next_s == WAIT)) begin
        wait_cnt_r <= wait_cnt_inc_s;
      end else begin
        wait_cnt_r <= 8'd0;
      end
      if (load_rsp_s) begin
        rsp_data_r   <= rsp_data_s;
        rsp_status_r <= rsp_status_s;
      end
      rsp_valid_r <= (state_next_s == RESP);
    end
  end

endmodule

// File: tb/tb_rf_access_master.sv
// Directed bench for rf_access_master: reset, write, delayed read, decode miss,
// timeout and its boundary, back-to-back with response backpressure, reset mid-access.
module tb_rf_access_master;

  logic clk;
  logic res;
  int   checks;
  int   failures;
  int   rd_cnt;
  int   wr_cnt;
  int   both_cnt;

  rf_access_master_if #(.ADDR_HI(5), .ADDR_LO(3), .DATA_W(64)) bus ();

  rf_access_master #(.ADDR_HI(5), .ADDR_LO(3), .DATA_W(64), .TIMEOUT(15)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (!res) begin
      if (bus.read_en) rd_cnt = rd_cnt + 1;
      if (bus.write_en) wr_cnt = wr_cnt + 1;
      if (bus.read_en && bus.write_en) both_cnt = both_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [2:0] a, input logic [63:0] d);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = w;
    bus.cmd_address = a;
    bus.cmd_wdata   = d;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    tick();
    tick();
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", bus.cmd_ready); end
    checks++; if ({bus.read_en, bus.write_en, bus.rsp_valid} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.read_en, bus.write_en, bus.rsp_valid}); end
    checks++; if (bus.rsp_data !== 64'd0 || bus.rsp_status !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%h/%b exp=0/00", bus.rsp_data, bus.rsp_status); end
    checks++; if (bus.address !== 3'd0 || bus.write_data !== 64'd0) begin failures++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", bus.address, bus.write_data); end
    res = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_write();
    int wr0;
    wr0 = wr_cnt;
    send(1'b1, 3'd3, 64'h1234);
    bus.access_complete = 1'b1;
    checks++; if ({bus.write_en, bus.read_en} !== 2'b10) begin failures++; $display("FAIL wr_strobe got=%b exp=10", {bus.write_en, bus.read_en}); end
    checks++; if (bus.address !== 3'd3 || bus.write_data !== 64'h1234) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=3/1234", bus.address, bus.write_data); end
    checks++; if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_issue_ready got=%b%b exp=00", bus.cmd_ready, bus.rsp_valid); end
    tick();
    bus.access_complete = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.write_en !== 1'b0) begin failures++; $display("FAIL wr_latency got=%b%b exp=10", bus.rsp_valid, bus.write_en); end
    checks++; if (bus.rsp_status !== 2'b00 || bus.rsp_data !== 64'd0) begin failures++; $display("FAIL wr_rsp got=%b/%h exp=00/0", bus.rsp_status, bus.rsp_data); end
    checks++; if (bus.address !== 3'd3 || bus.write_data !== 64'h1234) begin failures++; $display("FAIL wr_hold got=%h/%h exp=3/1234", bus.address, bus.write_data); end
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_return got=%b%b exp=10", bus.cmd_ready, bus.rsp_valid); end
    checks++; if (wr_cnt - wr0 !== 1) begin failures++; $display("FAIL wr_pulses got=%0d exp=1", wr_cnt - wr0); end
  endtask

  task automatic test_read_delayed();
    int rd0;
    rd0 = rd_cnt;
    send(1'b0, 3'd1, 64'd0);
    checks++; if ({bus.read_en, bus.write_en} !== 2'b10 || bus.address !== 3'd1) begin failures++; $display("FAIL rd_strobe got=%b/%h exp=10/1", {bus.read_en, bus.write_en}, bus.address); end
    tick();
    checks++; if (bus.read_en !== 1'b0) begin failures++; $display("FAIL rd_strobe_one got=%b exp=0", bus.read_en); end
    tick();
    tick();
    bus.access_complete = 1'b1;
    bus.read_data       = 64'hDEADBEEF;
    tick();
    bus.access_complete = 1'b0;
    bus.read_data       = 64'd0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'hDEADBEEF || bus.rsp_status !== 2'b00) begin failures++; $display("FAIL rd_rsp got=%b/%h/%b exp=1/deadbeef/00", bus.rsp_valid, bus.rsp_data, bus.rsp_status); end
    tick();
    checks++; if (rd_cnt - rd0 !== 1) begin failures++; $display("FAIL rd_pulses got=%0d exp=1", rd_cnt - rd0); end
  endtask

  task automatic test_invalid();
    send(1'b0, 3'd7, 64'd0);
    bus.access_complete = 1'b1;
    bus.invalid_address = 1'b1;
    bus.read_data       = 64'hAAAA_5555;
    tick();
    bus.access_complete = 1'b0;
    bus.invalid_address = 1'b0;
    bus.read_data       = 64'd0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b01 || bus.rsp_data !== 64'd0) begin failures++; $display("FAIL inv_rsp got=%b/%b/%h exp=1/01/0", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bus.rsp_ready = 1'b0;
    send(1'b0, 3'd2, 64'd0);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 16) begin failures++; $display("FAIL to_latency got=%0d exp=16", n); end
    checks++; if (bus.rsp_status !== 2'b10 || bus.rsp_data !== 64'd0) begin failures++; $display("FAIL to_rsp got=%b/%h exp=10/0", bus.rsp_status, bus.rsp_data); end
    bus.access_complete = 1'b1;
    bus.read_data       = 64'h77;
    tick();
    tick();
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b10 || bus.rsp_data !== 64'd0) begin failures++; $display("FAIL to_late_complete got=%b/%b/%h exp=1/10/0", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.read_en !== 1'b0) begin failures++; $display("FAIL to_idle_ignore got=%b%b%b exp=100", bus.cmd_ready, bus.rsp_valid, bus.read_en); end
    bus.access_complete = 1'b0;
    bus.read_data       = 64'd0;
  endtask

  task automatic test_timeout_boundary();
    send(1'b0, 3'd4, 64'd0);
    for (int i = 0; i < 15; i++) tick();
    bus.access_complete = 1'b1;
    bus.read_data       = 64'h55;
    tick();
    bus.access_complete = 1'b0;
    bus.read_data       = 64'd0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== 2'b00 || bus.rsp_data !== 64'h55) begin failures++; $display("FAIL to_boundary got=%b/%b/%h exp=1/00/55", bus.rsp_valid, bus.rsp_status, bus.rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    int rd0;
    rd0 = rd_cnt;
    bus.rsp_ready = 1'b0;
    send(1'b0, 3'd4, 64'd0);
    bus.cmd_valid       = 1'b1;
    bus.cmd_address     = 3'd5;
    bus.access_complete = 1'b1;
    bus.read_data       = 64'h1111;
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_issue_ready got=%b exp=0", bus.cmd_ready); end
    tick();
    bus.access_complete = 1'b0;
    bus.read_data       = 64'd0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h1111 || bus.rsp_status !== 2'b00 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold cyc=%0d got=%b/%h/%b/%b exp=1/1111/00/0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.cmd_ready); end
      if (i < 4) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || rd_cnt - rd0 !== 1) begin failures++; $display("FAIL b2b_stalled got=%b/%0d exp=1/1", bus.cmd_ready, rd_cnt - rd0); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if (bus.read_en !== 1'b1 || bus.address !== 3'd5) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1/5", bus.read_en, bus.address); end
    bus.access_complete = 1'b1;
    bus.read_data       = 64'h2222;
    tick();
    bus.access_complete = 1'b0;
    bus.read_data       = 64'd0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 64'h2222) begin failures++; $display("FAIL b2b_second_rsp got=%b/%h exp=1/2222", bus.rsp_valid, bus.rsp_data); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (rd_cnt - rd0 !== 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", rd_cnt - rd0); end
  endtask

  task automatic test_reset_in_wait();
    int rd0;
    int vcnt;
    send(1'b0, 3'd6, 64'd0);
    tick();
    tick();
    rd0 = rd_cnt;
    res = 1'b1;
    tick();
    checks++; if (bus.rsp_valid !== 1'b0 || bus.read_en !== 1'b0 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_wait_during got=%b%b%b exp=000", bus.rsp_valid, bus.read_en, bus.cmd_ready); end
    res = 1'b0;
    tick();
    checks++; if (bus.cmd_ready !== 1'b1 || bus.address !== 3'd0) begin failures++; $display("FAIL rst_wait_ready got=%b/%h exp=1/0", bus.cmd_ready, bus.address); end
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rsp_valid === 1'b1) vcnt++;
      tick();
    end
    checks++; if (vcnt !== 0 || rd_cnt - rd0 !== 0) begin failures++; $display("FAIL rst_wait_quiet got=%0d/%0d exp=0/0", vcnt, rd_cnt - rd0); end
  endtask

  initial begin
    checks              = 0;
    failures            = 0;
    rd_cnt              = 0;
    wr_cnt              = 0;
    both_cnt            = 0;
    res                 = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cmd_write       = 1'b0;
    bus.cmd_address     = 3'd0;
    bus.cmd_wdata       = 64'd0;
    bus.read_data       = 64'd0;
    bus.access_complete = 1'b0;
    bus.invalid_address = 1'b0;
    bus.rsp_ready       = 1'b1;
    test_reset();
    test_write();
    test_read_delayed();
    test_invalid();
    test_timeout();
    test_timeout_boundary();
    test_back_to_back();
    test_reset_in_wait();
    checks++; if (both_cnt !== 0) begin failures++; $display("FAIL both_strobes got=%0d exp=0", both_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_access_master.md
RF_ACCESS_MASTER -- requirements
Module: rf_access_master

Interface
REQ-001 Parameters SHALL be:
- ADDR_HI, default 5, upper register-file address bit.
- ADDR_LO, default 3, lower register-file address bit (8-byte word granularity).
- DATA_W, default 64, data width.
- TIMEOUT, default 15, wait cycles before an access is aborted (1..255).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- res  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_address  in  ADDR_HI-ADDR_LO+1  target register address.
- cmd_wdata  in  DATA_W  write payload.
- address  out  ADDR_HI:ADDR_LO  register-file address.
- read_en  out  1  register-file read strobe.
- write_en  out  1  register-file write strobe.
- write_data  out  DATA_W  register-file write data.
- read_data  in  DATA_W  register-file read data.
- access_complete  in  1  register-file access done.
- invalid_address  in  1  register-file address decode miss.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_data  out  DATA_W  read data; 0 for writes and errors.
- rsp_status  out  2  00 OK, 01 INVALID, 10 TIMEOUT, 11 unused.

Function
REQ-003 The block SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with at most one access outstanding.
REQ-004 IDLE: cmd_ready SHALL be 1; on cmd_valid&&cmd_ready the block SHALL register cmd_write, cmd_address and cmd_wdata, then go to ISSUE.
REQ-005 cmd_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-006 ISSUE, which lasts exactly one cycle:
- Exactly one of read_en/write_en SHALL be 1, selected by the registered cmd_write.
- address SHALL carry the registered address; write_data SHALL carry the registered payload.
- Next state SHALL be WAIT.
REQ-007 read_en and write_en SHALL never both be 1 and SHALL be 0 in every state other than ISSUE.
REQ-008 address and write_data SHALL hold their registered values from ISSUE until the return to IDLE.
REQ-009 access_complete or invalid_address sampled high in the ISSUE cycle or in any WAIT cycle SHALL terminate the access, and the next state SHALL be RESP.
REQ-010 Simultaneous access_complete and invalid_address SHALL yield status INVALID, and rsp_data SHALL be 0.
REQ-011 On access_complete alone, status SHALL be OK; for reads rsp_data SHALL capture read_data in that same cycle, and for writes rsp_data SHALL be 0.
REQ-012 Timeout: the WAIT cycle counter (8 bit) SHALL clear on entry to WAIT.
- When TIMEOUT consecutive WAIT cycles pass without termination, the next state SHALL be RESP with status TIMEOUT and rsp_data 0.
- access_complete arriving in the same cycle the count reaches TIMEOUT SHALL win and produce status OK.
REQ-013 RESP: rsp_valid SHALL be 1 and rsp_data/rsp_status SHALL be held stable until rsp_ready; on rsp_valid&&rsp_ready the next state SHALL be IDLE.
REQ-014 Latency: with access_complete high in the ISSUE cycle and rsp_ready held high, rsp_valid SHALL rise 2 cycles after command acceptance, and cmd_ready SHALL return 1 cycle after that.
REQ-015 access_complete or invalid_address arriving in IDLE or RESP SHALL be ignored and SHALL NOT change any state or output.
REQ-016 A command offered while the block is busy SHALL remain pending on cmd_valid; it SHALL NOT be lost or duplicated.

Reset
REQ-017 With res high at a rising clk edge, the FSM SHALL enter IDLE, and the following outputs SHALL be 0: read_en, write_en, rsp_valid, rsp_data, rsp_status, address, write_data, timeout counter.
REQ-018 Reset asserted in ISSUE, WAIT or RESP SHALL abort the access immediately: no response SHALL be produced, and no strobe SHALL be issued in the following cycle.
REQ-019 cmd_ready SHALL be 0 while res is high and SHALL be 1 in the first cycle after res deasserts.

Verification
REQ-020 Write 0x1234 to address 3 with the responder asserting access_complete in the ISSUE cycle -> write_en pulse of one cycle, address=3, write_data=0x1234, rsp_status=00, rsp_data=0, rsp_valid 2 cycles after acceptance.
REQ-021 Read of address 1 with access_complete 3 cycles after the strobe and read_data=0xDEADBEEF in that cycle -> single read_en pulse, rsp_data=0xDEADBEEF, rsp_status=00.
REQ-022 Read of address 7 with invalid_address and access_complete both high -> rsp_status=01, rsp_data=0.
REQ-023 Silent responder with TIMEOUT=15 -> rsp_valid exactly 15 WAIT cycles after ISSUE, rsp_status=10; a late access_complete then has no effect.
REQ-024 Back-to-back reads with rsp_ready held low for 5 cycles -> response held stable for those cycles, second command stalled with cmd_ready=0, then issued once.
REQ-025 res pulsed during WAIT -> no rsp_valid, no further strobes, cmd_ready=1 in the cycle after res falls.
